// File: rtl/mem_pkg.sv
// Shared sizing, types and address-to-word-index helper for the mini-CPU memories.
// Also used by the instruction-memory block.
package mem_pkg;
  localparam int XLEN     = 64;
  localparam int DEPTH    = 1024;
  localparam int ADDR_LSB = 3;
  localparam int INDEX_W  = $clog2(DEPTH);

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [INDEX_W-1:0] index_t;

  // Byte offset and bits above the array span are dropped: misaligned
  // addresses hit the containing word and the array wraps modulo DEPTH.
  function automatic index_t addr_to_index(input word_t addr);
    return addr[ADDR_LSB +: INDEX_W];
  endfunction
endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between datapath and data memory: address, write data, strobes, read data.
// No flow control; the memory always accepts and answers in the same cycle.
interface data_memory_if;
  import mem_pkg::*;

  word_t address;
  word_t write_data;
  logic  write_en;
  logic  read_en;
  word_t read_data;

  modport master (
    output address,
    output write_data,
    output write_en,
    output read_en,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  write_en,
    input  read_en,
    output read_data
  );
endinterface

// File: rtl/data_memory.sv
// Single-port XLEN x DEPTH data memory: synchronous write, combinational read (zero wait states).
// Never stalls; synchronous reset clears every word and wins over a concurrent write.
module data_memory
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  word_t  mem_q [DEPTH];
  index_t idx;
  logic   wr_vld_d;
  index_t wr_idx_d;
  word_t  wr_dat_d;
  logic   unused_addr_bits;

  always_comb begin
    idx      = addr_to_index(bus.address);
    wr_vld_d = bus.write_en;
    wr_idx_d = idx;
    wr_dat_d = bus.write_data;
  end

  assign unused_addr_bits = ^{bus.address[XLEN-1:ADDR_LSB+INDEX_W],
                              bus.address[ADDR_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_vld_d) begin
      mem_q[wr_idx_d] <= wr_dat_d;
    end
  end

  // No write bypass: a same-index read shows the old word until the edge.
  assign bus.read_data = bus.read_en ? mem_q[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: per-scenario tasks, expected words queued then popped on read.
module tb_data_memory;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  word_t exp_q[$];

  data_memory_if bus();

  data_memory dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    word_t exp;
    @(negedge clk);
    rst = 1'b1; bus.write_en = 1'b1; bus.address = 64'd4; bus.write_data = 64'd5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.address = word_t'(i) << ADDR_LSB;
      exp_q.push_back('0);
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.read_data !== exp) begin
        n_err++;
        $display("FAIL reset_clear idx=%0d got=%h want=%h", i, bus.read_data, exp);
      end
    end
  endtask

  task automatic test_basic_write();
    word_t exp;
    @(negedge clk);
    bus.address = 64'd4; bus.write_data = 64'd5; bus.write_en = 1'b1; bus.read_en = 1'b0;
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd5);
    @(posedge clk);
    @(negedge clk);
    bus.write_en = 1'b0; bus.read_en = 1'b1;
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL basic_rd addr=4 got=%h want=%h", bus.read_data, exp);
    end
    bus.address = 64'd0;
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL basic_alias addr=0 got=%h want=%h", bus.read_data, exp);
    end
  endtask

  task automatic test_read_enable();
    word_t exp;
    @(negedge clk);
    bus.address = 64'd8; bus.write_data = 64'hDEADBEEF_CAFEF00D; bus.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_en = 1'b0; bus.read_en = 1'b0;
    exp_q.push_back('0);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL rd_gate_off got=%h want=%h", bus.read_data, exp);
    end
    bus.read_en = 1'b1;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL rd_gate_on got=%h want=%h", bus.read_data, exp);
    end
  endtask

  task automatic test_wrap_align();
    word_t exp;
    word_t addrs [3];
    addrs[0] = 64'd8200; addrs[1] = 64'd15; addrs[2] = 64'd16;
    @(negedge clk);
    bus.address = 64'd8; bus.write_data = 64'h1234; bus.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_en = 1'b0; bus.read_en = 1'b1;
    exp_q.push_back(64'h1234);
    exp_q.push_back(64'h1234);
    exp_q.push_back('0);
    for (int i = 0; i < 3; i++) begin
      bus.address = addrs[i];
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.read_data !== exp) begin
        n_err++;
        $display("FAIL wrap_align addr=%0d got=%h want=%h", addrs[i], bus.read_data, exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    word_t exp;
    @(negedge clk);
    bus.address = 64'd16; bus.write_data = 64'd7; bus.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_data = 64'd9; bus.write_en = 1'b1; bus.read_en = 1'b1;
    exp_q.push_back(64'd7);
    exp_q.push_back(64'd9);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL rdw_before got=%h want=%h", bus.read_data, exp);
    end
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL rdw_after got=%h want=%h", bus.read_data, exp);
    end
    @(negedge clk);
    bus.write_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    word_t exp;
    word_t dat;
    bus.read_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dat = {$urandom, $urandom};
      bus.address = word_t'(100 + i) << ADDR_LSB;
      bus.write_data = dat;
      bus.write_en = 1'b1;
      exp_q.push_back(dat);
    end
    @(negedge clk);
    bus.write_en = 1'b0; bus.read_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.address = (word_t'(100 + i) << ADDR_LSB) | word_t'(i % 8);
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.read_data !== exp) begin
        n_err++;
        $display("FAIL b2b idx=%0d got=%h want=%h", 100 + i, bus.read_data, exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    word_t exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.address = word_t'(i) << ADDR_LSB;
      bus.write_data = word_t'(i + 1);
      bus.write_en = 1'b1;
    end
    @(negedge clk);
    bus.write_en = 1'b0; bus.read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.address = word_t'(i) << ADDR_LSB;
      exp_q.push_back(word_t'(i + 1));
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.read_data !== exp) begin
        n_err++;
        $display("FAIL fill idx=%0d got=%h want=%h", i, bus.read_data, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1; bus.write_en = 1'b1; bus.address = 64'd24; bus.write_data = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.write_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.address = word_t'(i) << ADDR_LSB;
      exp_q.push_back('0);
      #1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.read_data !== exp) begin
        n_err++;
        $display("FAIL mid_reset idx=%0d got=%h want=%h", i, bus.read_data, exp);
      end
    end
    bus.address = word_t'(100) << ADDR_LSB;
    exp_q.push_back('0);
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (bus.read_data !== exp) begin
      n_err++;
      $display("FAIL mid_reset_far idx=100 got=%h want=%h", bus.read_data, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.address = '0;
    bus.write_data = '0;
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    test_reset();
    test_basic_write();
    test_read_enable();
    test_wrap_align();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid_op();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port data memory for the mini-CPU's load/store path: 1024 words of XLEN bits.
- Writes are synchronous; reads are combinational.
- Sits between the datapath ALU (address) / register file (write data) and the writeback mux (read data).
- Whole array is cleared by a synchronous reset.

Parameters:
- XLEN, 64, data and address width in bits.
- DEPTH, 1024, number of XLEN-bit words; must be a power of two.
- ADDR_LSB, 3, byte-offset bits ignored when forming the word index (log2(XLEN/8)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- address  input  XLEN  byte address; word index = address[ADDR_LSB +: log2(DEPTH)].
- write_data  input  XLEN  data written on a write.
- write_en  input  1  write strobe, sampled at the rising edge.
- read_en  input  1  read enable, combinational.
- read_data  output  XLEN  word at the current address when read_en=1, else 0.

Behaviour:
- Storage is mem[0..DEPTH-1], each XLEN bits.
- Reset: at a rising edge with rst=1, every word becomes 0.
  - Reset has priority over write_en; a write requested during reset is discarded.
  - Reset takes one edge regardless of prior contents.
- Write: at a rising edge with rst=0 and write_en=1, mem[idx] <= write_data. The full word is written; there are no byte enables.
- Read: read_data = read_en ? mem[idx] : 0, purely combinational from address, read_en and array contents.
  - Zero wait states: data is valid in the same cycle the address is presented.
- Read-during-write, same index:
  - Before the edge, read_data shows the old word.
  - After the edge, it shows the newly written word (write-first is not required; no bypass).
- Address bits:
  - Low ADDR_LSB bits are ignored, so misaligned addresses map to the containing word; no fault is raised.
  - Bits above ADDR_LSB+log2(DEPTH)-1 are ignored, so the address wraps modulo DEPTH words.
- After reset release, contents persist until overwritten; there is no other clearing mechanism.
- Outputs contain no X after the first reset edge.
- Before the first reset, contents are undefined. A simulation model initialises them to 0.
- write_en and read_en are independent; both may be high in the same cycle.

Decomposition:
- Shared package mem_pkg holds:
  - XLEN, DEPTH, ADDR_LSB and the derived INDEX_W = $clog2(DEPTH);
  - typedef word_t (logic [XLEN-1:0]);
  - typedef index_t (logic [INDEX_W-1:0]).
- No sub-module is needed. The index extraction is a single function in the package (addr_to_index), reused by the instruction-memory block.

Test Plan:
- Write during reset: hold rst=1, write_en=1, address=4, write_data=5 for one edge; then read_en=1 sweeps indices 0..1023 -> read_data=0 at every index.
- Basic write/read: rst=0, write_en=1, address=4, write_data=5, one edge -> read_data=5 with read_en=1. address=0 aliases the same word -> 5.
- Read enable gating: with mem[1]=0xDEADBEEF_CAFEF00D, read_en=0 -> read_data=0; read_en=1 -> 0xDEADBEEF_CAFEF00D in the same cycle, with no edge needed.
- Wrap and alignment:
  - write 0x1234 at address 8 -> reading address 8+8*1024=8200 returns 0x1234;
  - address 15 returns 0x1234;
  - address 16 is unaffected (0).
- Read-during-write: mem[2]=7; set address=16, write_data=9, write_en=1 -> read_data=7 before the edge, 9 after the edge.
- Reset mid-operation: fill indices 0..3 with 1..4, assert rst for one edge together with write_en=1 -> all four read 0 and the concurrent write is discarded.
